// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: jump-mode
// encodings and default parameter values.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    MODE_JUMP = 2'd0,
    MODE_SEQ  = 2'd1,
    MODE_REG  = 2'd2,
    MODE_RET  = 2'd3
  } jump_mode_e;

  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_JUMP_W    = 26;
  localparam int unsigned DEF_RAS_DEPTH = 4;
  localparam int unsigned DEF_BR_SHIFT  = 0;
  localparam int unsigned DEF_PC_INC    = 4;
  localparam int unsigned DEF_RESET_PC  = 0;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: circular buffer with a top pointer and an
// occupancy count. Overflow overwrites the oldest entry; underflow
// pops leave the state untouched and raise a one-cycle pulse.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  input  logic            stall,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   top;
  logic [CW-1:0]   count;
  logic            replace;

  assign empty    = (count == '0);
  assign full     = (count == CW'(RAS_DEPTH));
  assign top_data = mem[top];
  // A pop that meets a push on a non-empty stack rewrites the top in place.
  assign replace  = push && pop && !empty;

  // Pointer, count and flag state; stall freezes everything and masks unf.
  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (stall) begin
      unf <= 1'b0;
    end else begin
      unf <= pop && empty;
      if (replace) begin
        top <= top;
      end else if (push) begin
        top <= top + 1'b1;
        if (full) ovf   <= 1'b1;
        else      count <= count + 1'b1;
      end else if (pop && !empty) begin
        top   <= top - 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (!rst && !stall && push) begin
      if (replace) mem[top]        <= push_data;
      else         mem[top + 1'b1] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-address mux, adders, registered PC
// and a return-address stack for call/return.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned JUMP_W    = DEF_JUMP_W,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int unsigned BR_SHIFT  = DEF_BR_SHIFT,
  parameter int unsigned PC_INC    = DEF_PC_INC,
  parameter int unsigned RESET_PC  = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        jump_mode,
  input  logic              call,
  input  logic              branch,
  input  logic              branch_valid,
  input  logic [JUMP_W-1:0] jump_val,
  input  logic [XLEN-1:0]   se_offset,
  input  logic [XLEN-1:0]   reg_target,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus,
  output logic [XLEN-1:0]   next_addr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] target;
  logic            ret;

  assign pc_plus = pc + XLEN'(PC_INC);
  assign br_off  = se_offset << BR_SHIFT;
  assign ret     = (jump_mode == MODE_RET);

  // Target selection by jump mode; empty-stack return falls back to reg_target.
  always_comb begin
    target = pc_plus;
    case (jump_mode_e'(jump_mode))
      MODE_JUMP: target = XLEN'(jump_val);
      MODE_SEQ:  target = (branch && branch_valid) ? pc_plus + br_off : pc_plus;
      MODE_REG:  target = reg_target;
      MODE_RET:  target = ras_empty ? reg_target : ras_top;
      default:   target = pc_plus;
    endcase
    next_addr = rst ? XLEN'(RESET_PC) : target;
  end

  // PC register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (rst)         pc <= XLEN'(RESET_PC);
    else if (!stall) pc <= next_addr;
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (call),
    .pop       (ret),
    .push_data (pc_plus),
    .stall     (stall),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected PCs are queued when a
// cycle is driven and popped/compared after the edge that loads pc.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, call, branch, branch_valid;
  logic [1:0]  jump_mode;
  logic [25:0] jump_val;
  logic [31:0] se_offset, reg_target;
  logic [31:0] pc, pc_plus, next_addr;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN(32), .JUMP_W(26), .RAS_DEPTH(4), .BR_SHIFT(0), .PC_INC(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_mode(jump_mode), .call(call),
    .branch(branch), .branch_valid(branch_valid), .jump_val(jump_val),
    .se_offset(se_offset), .reg_target(reg_target), .pc(pc), .pc_plus(pc_plus),
    .next_addr(next_addr), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Drive one cycle's inputs at the falling edge, settle before the next edge.
  task automatic drive(input logic [1:0] m, input logic c, input logic b, input logic bv,
                       input logic [25:0] jv, input logic [31:0] off, input logic [31:0] rt,
                       input logic st, input logic r);
    @(negedge clk);
    jump_mode = m; call = c; branch = b; branch_valid = bv;
    jump_val = jv; se_offset = off; reg_target = rt; stall = st; rst = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain sequential cycle or register jump, used to position the PC.
  task automatic go(input logic [1:0] m, input logic c, input logic [25:0] jv, input logic [31:0] rt);
    drive(m, c, 1'b0, 1'b0, jv, 32'h0, rt, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    drive(2'd1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(2'd2, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    checks++;
    if (next_addr !== 32'h0) begin $display("FAIL reset_next_addr got=%h exp=%h", next_addr, 32'h0); failures++; end
    tick();
    checks++;
    if (pc !== 32'h0) begin $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); failures++; end
    checks++;
    if ({ras_empty, ras_full, ras_ovf, ras_unf} !== 4'b1000) begin
      $display("FAIL reset_flags got=%b exp=%b", {ras_empty, ras_full, ras_ovf, ras_unf}, 4'b1000); failures++;
    end
  endtask

  task automatic test_seq();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(32'(4 * i));
      go(2'd1, 1'b0, 26'h0, 32'h0);
      exp_v = exp_q.pop_front();
      checks++;
      if (pc !== exp_v) begin $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp_v); failures++; end
    end
    checks++;
    if (ras_empty !== 1'b1) begin $display("FAIL seq_empty got=%b exp=1", ras_empty); failures++; end
  endtask

  task automatic test_branch();
    go(2'd2, 1'b0, 26'h0, 32'h10);
    drive(2'd1, 1'b0, 1'b1, 1'b1, 26'h0, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
    exp_q.push_back(32'h0C);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (pc !== exp_v) begin $display("FAIL branch_taken got=%h exp=%h", pc, exp_v); failures++; end
    go(2'd2, 1'b0, 26'h0, 32'h10);
    drive(2'd1, 1'b0, 1'b1, 1'b0, 26'h0, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
    exp_q.push_back(32'h14);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (pc !== exp_v) begin $display("FAIL branch_not_taken got=%h exp=%h", pc, exp_v); failures++; end
  endtask

  task automatic test_call_ret();
    do_reset();
    go(2'd2, 1'b0, 26'h0, 32'h20);
    exp_q.push_back(32'h100);
    go(2'd0, 1'b1, 26'h100, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (pc !== exp_v) begin $display("FAIL call_pc got=%h exp=%h", pc, exp_v); failures++; end
    checks++;
    if (ras_empty !== 1'b0) begin $display("FAIL call_nonempty got=%b exp=0", ras_empty); failures++; end
    drive(2'd3, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h999, 1'b0, 1'b0);
    checks++;
    if (next_addr !== 32'h24) begin $display("FAIL ret_next_addr got=%h exp=%h", next_addr, 32'h24); failures++; end
    exp_q.push_back(32'h24);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (pc !== exp_v) begin $display("FAIL ret_pc got=%h exp=%h", pc, exp_v); failures++; end
    checks++;
    if (ras_empty !== 1'b1) begin $display("FAIL ret_empty got=%b exp=1", ras_empty); failures++; end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(32'(16 * i));
      go(2'd0, 1'b1, 26'(16 * i), 32'h0);
      exp_v = exp_q.pop_front();
      checks++;
      if (pc !== exp_v) begin $display("FAIL ovf_call%0d got=%h exp=%h", i, pc, exp_v); failures++; end
      if (i == 4) begin
        checks++;
        if ({ras_full, ras_ovf} !== 2'b10) begin $display("FAIL full_no_ovf got=%b exp=10", {ras_full, ras_ovf}); failures++; end
      end
    end
    checks++;
    if ({ras_full, ras_ovf} !== 2'b11) begin $display("FAIL full_ovf got=%b exp=11", {ras_full, ras_ovf}); failures++; end
    exp_q.push_back(32'h44); exp_q.push_back(32'h34); exp_q.push_back(32'h24); exp_q.push_back(32'h14);
    exp_q.push_back(32'h80);
    for (int i = 1; i <= 5; i++) begin
      go(2'd3, 1'b0, 26'h0, 32'h80);
      exp_v = exp_q.pop_front();
      checks++;
      if (pc !== exp_v) begin $display("FAIL pop%0d got=%h exp=%h", i, pc, exp_v); failures++; end
      checks++;
      if (ras_unf !== (i == 5)) begin $display("FAIL pop%0d_unf got=%b exp=%b", i, ras_unf, (i == 5)); failures++; end
    end
    go(2'd1, 1'b0, 26'h0, 32'h0);
    checks++;
    if ({ras_empty, ras_ovf, ras_unf} !== 3'b110) begin
      $display("FAIL after_unf got=%b exp=110", {ras_empty, ras_ovf, ras_unf}); failures++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    go(2'd0, 1'b1, 26'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(2'd3, 1'b1, 1'b0, 1'b0, 26'h0, 32'h0, 32'h77, 1'b1, 1'b0);
      checks++;
      if (next_addr !== 32'h4) begin $display("FAIL stall_next_addr%0d got=%h exp=%h", i, next_addr, 32'h4); failures++; end
      exp_q.push_back(32'h100);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (pc !== exp_v) begin $display("FAIL stall_pc%0d got=%h exp=%h", i, pc, exp_v); failures++; end
      checks++;
      if ({ras_empty, ras_ovf, ras_unf} !== 3'b000) begin
        $display("FAIL stall_flags%0d got=%b exp=000", i, {ras_empty, ras_ovf, ras_unf}); failures++;
      end
    end
    exp_q.push_back(32'h4);
    go(2'd3, 1'b0, 26'h0, 32'h77);
    exp_v = exp_q.pop_front();
    checks++;
    if ({pc, ras_empty} !== {exp_v, 1'b1}) begin $display("FAIL stall_then_pop got=%h/%b exp=%h/1", pc, ras_empty, exp_v); failures++; end
    go(2'd0, 1'b1, 26'h200, 32'h0);
    drive(2'd1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    exp_q.push_back(32'h0);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if ({pc, ras_empty} !== {exp_v, 1'b1}) begin $display("FAIL rst_in_stall got=%h/%b exp=%h/1", pc, ras_empty, exp_v); failures++; end
  endtask

  task automatic test_wrap();
    do_reset();
    go(2'd2, 1'b0, 26'h0, 32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    go(2'd1, 1'b0, 26'h0, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (pc !== exp_v) begin $display("FAIL wrap got=%h exp=%h", pc, exp_v); failures++; end
    exp_q.push_back(32'h1234);
    go(2'd2, 1'b0, 26'h0, 32'h1234);
    exp_v = exp_q.pop_front();
    checks++;
    if (pc !== exp_v) begin $display("FAIL reg_jump got=%h exp=%h", pc, exp_v); failures++; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    go(2'd0, 1'b1, 26'h40, 32'h0);
    exp_q.push_back(32'h4); exp_q.push_back(32'h44);
    go(2'd3, 1'b1, 26'h0, 32'h300);
    exp_v = exp_q.pop_front();
    checks++;
    if ({pc, ras_empty} !== {exp_v, 1'b0}) begin $display("FAIL replace got=%h/%b exp=%h/0", pc, ras_empty, exp_v); failures++; end
    go(2'd3, 1'b0, 26'h0, 32'h300);
    exp_v = exp_q.pop_front();
    checks++;
    if ({pc, ras_empty} !== {exp_v, 1'b1}) begin $display("FAIL replace_pop got=%h/%b exp=%h/1", pc, ras_empty, exp_v); failures++; end
    exp_q.push_back(32'h200); exp_q.push_back(32'h48);
    go(2'd3, 1'b1, 26'h0, 32'h200);
    exp_v = exp_q.pop_front();
    checks++;
    if ({pc, ras_empty, ras_unf} !== {exp_v, 2'b01}) begin
      $display("FAIL empty_replace got=%h/%b%b exp=%h/01", pc, ras_empty, ras_unf, exp_v); failures++;
    end
    go(2'd3, 1'b0, 26'h0, 32'h500);
    exp_v = exp_q.pop_front();
    checks++;
    if ({pc, ras_empty, ras_unf} !== {exp_v, 2'b10}) begin
      $display("FAIL empty_replace_pop got=%h/%b%b exp=%h/10", pc, ras_empty, ras_unf, exp_v); failures++;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; call = 1'b0; branch = 1'b0; branch_valid = 1'b0;
    jump_mode = 2'd1; jump_val = '0; se_offset = '0; reg_target = '0;
    test_reset();
    test_seq();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall();
    test_wrap();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the KGP-miniRISC datapath. It supersedes the purely combinational next-address selection with three additions: a registered PC, a stall hold, and a return-address stack (RAS) for call/return. It sits between instruction fetch and the decode/branch-resolution logic, and drives the instruction-memory address every cycle.

## Interface
Parameters:
- XLEN, 32, datapath/address width.
- JUMP_W, 26, width of absolute jump field; zero-extended to XLEN.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- BR_SHIFT, 0, left shift applied to sign-extended branch offset.
- PC_INC, 4, sequential increment.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold PC and RAS this cycle.
- jump_mode  in  2  0 = absolute jump, 1 = sequential/branch, 2 = register, 3 = return (RAS pop).
- call  in  1  push PC+PC_INC onto RAS when this cycle's transfer commits.
- branch  in  1  instruction is a conditional branch.
- branch_valid  in  1  branch condition true.
- jump_val  in  JUMP_W  absolute target field.
- se_offset  in  XLEN  sign-extended branch offset.
- reg_target  in  XLEN  register-indirect target (read_data1).
- pc  out  XLEN  current PC (registered).
- pc_plus  out  XLEN  pc + PC_INC (combinational).
- next_addr  out  XLEN  address loaded into pc at the next edge.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  sticky: a push occurred while full.
- ras_unf  out  1  one-cycle pulse: a pop was attempted while empty.

## Operation
- Target selection (combinational):
  - mode 0 → {0, jump_val}.
  - mode 1 → pc_plus + (se_offset << BR_SHIFT) if branch & branch_valid, else pc_plus.
  - mode 2 → reg_target.
  - mode 3 → RAS top; if empty, reg_target.
- All additions are modulo 2^XLEN; overflow wraps silently.
- While rst is high, next_addr = RESET_PC.
- On each edge with !stall: pc ← next_addr.
- RAS is a circular buffer: top pointer plus count (0..RAS_DEPTH).
- Push (call & !stall) stores pc_plus at top+1.
  - When full, it overwrites the oldest entry; count stays RAS_DEPTH; ras_ovf is set.
- Pop (mode 3 & !stall):
  - When non-empty, it decrements top/count.
  - When empty, nothing changes, the target falls back to reg_target, and ras_unf pulses.
- Simultaneous pop and push (mode 3 with call) is a replace: the top entry is overwritten with pc_plus and count is unchanged. The returned target is the old top. An empty RAS behaves as a push plus ras_unf.
- stall overrides everything: pc, RAS contents, pointers and flags hold, and ras_unf stays 0. next_addr still reflects current inputs.

## Timing
- Reset values: pc = RESET_PC, count = 0, top = 0, ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0. RAS entry contents are don't-care.
- pc latency is one cycle: next_addr computed in cycle N appears on pc in cycle N+1.
- A RAS top written in cycle N is returnable by a mode-3 pop in cycle N+1 (no bypass needed within a cycle).
- ras_unf is registered and asserts in the cycle after the offending pop.
- ras_ovf clears only on rst.
- rst asserted mid-sequence discards RAS contents at the next edge. It takes priority over stall.

## Structure
- Package pc_seq_pkg holds:
  - mode constants MODE_JUMP = 2'd0, MODE_SEQ = 2'd1, MODE_REG = 2'd2, MODE_RET = 2'd3;
  - the default parameter values.
- Sub-module ras_stack (parameters XLEN, RAS_DEPTH) contains the storage, pointer, count and flags. Its inputs are push, pop, push_data and stall; its outputs are top_data, empty, full, ovf and unf.
- The top level holds the target mux, adders and PC register.

## Test plan
- Reset then 3 unstalled cycles in mode 1, no branch → pc = 0, 4, 8, 12; ras_empty = 1.
- pc = 0x10, mode 1, branch = branch_valid = 1, se_offset = 0xFFFFFFF8, BR_SHIFT = 0 → next pc = 0x0C. Repeat with branch_valid = 0 → 0x14.
- Call/return:
  - pc = 0x20, mode 0, jump_val = 0x100, call = 1 → pc = 0x100 and RAS top = 0x24.
  - Then mode 3 → pc = 0x24, ras_empty = 1.
- Five calls with RAS_DEPTH = 4 from pcs 0x0, 0x10, 0x20, 0x30, 0x40 → ras_full = 1 and ras_ovf = 1. Four pops return 0x44, 0x34, 0x24, 0x14; a fifth pop returns reg_target = 0x80 and pulses ras_unf.
- stall = 1 for 3 cycles while in mode 3 with call = 1 → pc and RAS count unchanged and no flags. rst during a stall → pc = RESET_PC next cycle and ras_empty = 1.
- pc = 0xFFFFFFFC, mode 1 → pc wraps to 0x0; mode 2 with reg_target = 0x1234 → pc = 0x1234.
